// File: rtl/acc_to_fp16.sv
// Converts a MAC {exp, signed fixed-point accumulator} pair into an IEEE FP16 value (RNE, flush-to-zero).
// Optional build macro ACC2FP_SAT_EN: overflow saturates to max finite instead of infinity.
module acc_to_fp16 #(
  parameter int ACC_WIDTH = 32,
  parameter int EXP_WIDTH = 5,
  parameter int FRAC_BITS = 10,
  parameter int BIAS      = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_WIDTH-1:0] acc_in,
  input  logic [EXP_WIDTH-1:0] exp_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          fp_out,
  output logic                 ovf,
  output logic                 unf
);

  localparam int LW = $clog2(ACC_WIDTH);
  localparam int EW = LW + EXP_WIDTH + 2;
  localparam int MW = FRAC_BITS + 1;
  localparam logic signed [EW-1:0] EXP_TOP  = EW'(2 * BIAS + 1);
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_RND  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  logic [1:0]           state_r;
  logic                 in_ready_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [EXP_WIDTH-1:0] exp_r;
  logic                 sign_r;
  logic                 zero_r;
  logic [ACC_WIDTH-1:0] norm_r;
  logic signed [EW-1:0] exp_norm_r;
  logic                 out_valid_r;
  logic [15:0]          fp_out_r;
  logic                 ovf_r;
  logic                 unf_r;

  logic [ACC_WIDTH-1:0] mag_s;
  logic [LW-1:0]        lead_s;
  logic [LW-1:0]        shamt_s;
  logic [ACC_WIDTH-1:0] norm_s;
  logic signed [EW-1:0] exp_norm_s;
  logic [MW-1:0]        mant_s;
  logic                 guard_s;
  logic                 sticky_s;
  logic [MW:0]          mant_sum_s;
  logic [MW-1:0]        mant_fin_s;
  logic signed [EW-1:0] exp_fin_s;
  logic [15:0]          fp_s;
  logic                 ovf_s;
  logic                 unf_s;

  function automatic logic [LW-1:0] lead_one(input logic [ACC_WIDTH-1:0] v);
    lead_one = '0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      lead_one = v[i] ? LW'(i) : lead_one;
    end
  endfunction

  // Normalise stage: magnitude, leading-one position, shift to MSB, unbiased-free exponent
  always_comb begin
    mag_s      = acc_r[ACC_WIDTH-1] ? (~acc_r + {{(ACC_WIDTH-1){1'b0}}, 1'b1}) : acc_r;
    lead_s     = lead_one(mag_s);
    shamt_s    = LW'(ACC_WIDTH - 1) - lead_s;
    norm_s     = mag_s << shamt_s;
    exp_norm_s = EW'(exp_r) + EW'(lead_s) - EW'(FRAC_BITS);
  end

  // Round stage: round-to-nearest-even and range check
  always_comb begin
    mant_s     = norm_r[ACC_WIDTH-1 -: MW];
    guard_s    = norm_r[ACC_WIDTH-MW-1];
    sticky_s   = |norm_r[ACC_WIDTH-MW-2:0];
    mant_sum_s = {1'b0, mant_s} + {{MW{1'b0}}, guard_s & (sticky_s | mant_s[0])};
    if (mant_sum_s[MW]) begin
      mant_fin_s = {1'b1, {FRAC_BITS{1'b0}}};
      exp_fin_s  = exp_norm_r + EW'(1);
    end else begin
      mant_fin_s = mant_sum_s[MW-1:0];
      exp_fin_s  = exp_norm_r;
    end
    ovf_s = 1'b0;
    unf_s = 1'b0;
    if (zero_r) begin
      fp_s = 16'h0000;
    end else if (exp_fin_s >= EXP_TOP) begin
      ovf_s = 1'b1;
`ifdef ACC2FP_SAT_EN
      fp_s = {sign_r, 15'h7BFF};
`else
      fp_s = {sign_r, 15'h7C00};
`endif
    end else if (exp_fin_s <= EXP_ZERO) begin
      unf_s = 1'b1;
      fp_s  = {sign_r, 15'h0000};
    end else begin
      fp_s = {sign_r, exp_fin_s[EXP_WIDTH-1:0], mant_fin_s[FRAC_BITS-1:0]};
    end
  end

  // Control FSM and pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      acc_r       <= '0;
      exp_r       <= '0;
      sign_r      <= 1'b0;
      zero_r      <= 1'b0;
      norm_r      <= '0;
      exp_norm_r  <= '0;
      out_valid_r <= 1'b0;
      fp_out_r    <= 16'h0000;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            acc_r      <= acc_in;
            exp_r      <= exp_in;
            in_ready_r <= 1'b0;
            state_r    <= ST_NORM;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_NORM: begin
          sign_r     <= acc_r[ACC_WIDTH-1];
          zero_r     <= (mag_s == '0);
          norm_r     <= norm_s;
          exp_norm_r <= exp_norm_s;
          state_r    <= ST_RND;
        end
        ST_RND: begin
          fp_out_r    <= fp_s;
          ovf_r       <= ovf_s;
          unf_r       <= unf_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          ovf_r       <= 1'b0;
          unf_r       <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign fp_out    = fp_out_r;
  assign ovf       = ovf_r;
  assign unf       = unf_r;

endmodule

// File: tb/tb_acc_to_fp16.sv
// Directed, table-driven bench for acc_to_fp16 with hand-computed FP16 results.
module tb_acc_to_fp16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] acc_in = 32'h0;
  logic [4:0]  exp_in = 5'd0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] fp_out;
  logic        ovf;
  logic        unf;

  int errors = 0;
  int checks = 0;

`ifdef ACC2FP_SAT_EN
  localparam logic [15:0] POS_OVF = 16'h7BFF;
  localparam logic [15:0] NEG_OVF = 16'hFBFF;
`else
  localparam logic [15:0] POS_OVF = 16'h7C00;
  localparam logic [15:0] NEG_OVF = 16'hFC00;
`endif

  typedef struct {
    logic [31:0] acc;
    logic [4:0]  exp;
    logic [15:0] fp;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[14];

  acc_to_fp16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .acc_in(acc_in), .exp_in(exp_in), .out_valid(out_valid), .out_ready(out_ready),
    .fp_out(fp_out), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic apply(input logic [31:0] a, input logic [4:0] e, input logic [15:0] fp,
                       input logic ov, input logic un, input string tag);
    wait_ready(tag);
    acc_in   = a;
    exp_in   = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, " lat1"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, " lat2"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " fp_out"}, {16'd0, fp_out}, {16'd0, fp});
    check({tag, " ovf"}, {31'd0, ovf}, {31'd0, ov});
    check({tag, " unf"}, {31'd0, unf}, {31'd0, un});
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, " drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, " ready_back"}, {31'd0, in_ready}, 32'd1);
    check({tag, " flags_clr"}, {30'd0, ovf, unf}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0002, 5'd16, 16'h1C00, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0400, 5'd15, 16'h3C00, 1'b0, 1'b0};
    vecs[2]  = '{32'hFFFF_FC00, 5'd15, 16'hBC00, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0801, 5'd15, 16'h4000, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000_0803, 5'd15, 16'h4002, 1'b0, 1'b0};
    vecs[5]  = '{32'h7FFF_FFFF, 5'd30, POS_OVF,  1'b1, 1'b0};
    vecs[6]  = '{32'h0000_0001, 5'd5,  16'h0000, 1'b0, 1'b1};
    vecs[7]  = '{32'h0000_0000, 5'd20, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{32'h8000_0000, 5'd15, NEG_OVF,  1'b1, 1'b0};
    vecs[9]  = '{32'hFFFF_FFFF, 5'd5,  16'h8000, 1'b0, 1'b1};
    vecs[10] = '{32'h0000_0FFF, 5'd15, 16'h4400, 1'b0, 1'b0};
    vecs[11] = '{32'h0000_0400, 5'd30, 16'h7800, 1'b0, 1'b0};
    vecs[12] = '{32'h0000_0FFF, 5'd29, POS_OVF,  1'b1, 1'b0};
    vecs[13] = '{32'h0000_0400, 5'd0,  16'h0000, 1'b0, 1'b1};

    // reset state and first ready edge
    #2;
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst outs", {14'd0, fp_out, ovf, unf}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("release in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("first edge in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].acc, vecs[i].exp, vecs[i].fp, vecs[i].ovf, vecs[i].unf, $sformatf("v%0d", i));
    end

    // output stall: result held, new input ignored
    wait_ready("stall");
    acc_in   = 32'h0000_0400;
    exp_in   = 5'd15;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("stall valid", {31'd0, out_valid}, 32'd1);
    acc_in   = 32'h0000_0803;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d fp_out", c), {16'd0, fp_out}, 32'h0000_3C00);
      check($sformatf("stall%0d valid", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("stall%0d in_ready", c), {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("stall release valid", {31'd0, out_valid}, 32'd0);
    check("stall release ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall idle%0d", c), {31'd0, out_valid}, 32'd0);
    end

    // reset while rounding discards the operation
    wait_ready("abort");
    acc_in   = 32'h0000_0400;
    exp_in   = 5'd15;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort in_ready", {31'd0, in_ready}, 32'd0);
    check("abort outs", {13'd0, out_valid, fp_out, ovf, unf}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("abort hold%0d", c), {31'd0, out_valid}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort recover ready", {31'd0, in_ready}, 32'd1);
    check("abort recover valid", {31'd0, out_valid}, 32'd0);
    apply(32'h0000_0803, 5'd15, 16'h4002, 1'b0, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
